fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetch FSM with
// redirect handling, an instruction holding register and decode slices.

package instruction_set_pkg;
  typedef logic [5:0] opcode_t;
  typedef logic [5:0] func_t;
endpackage

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req,
  output logic [31:0]                   imem_addr,
  input  logic                          imem_rvalid,
  input  logic [31:0]                   imem_rdata,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [31:0]                   instr,
  output instruction_set_pkg::opcode_t  opcode,
  output instruction_set_pkg::func_t    func,
  output logic [31:0]                   instr_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // Redirect targets are forced word-aligned; pc+4 wraps naturally at 2^32.
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign pc_plus4        = pc + 32'd4;

  // The address bus always shows pc; it is only meaningful while imem_req=1.
  assign imem_addr = pc;

  // Decode fields are plain slices of the held instruction.
  assign opcode = instr[31:26];
  assign func   = instr[5:0];

  // Fetch FSM: redirect wins over imem_rvalid and instr_ready in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          // Any late response from an access abandoned by reset is ignored here.
          if (redirect_valid) begin
            pc <= redirect_target;
          end
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            if (imem_rvalid) begin
              // Response consumed the outstanding slot; drop it and refetch.
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              // Response still in flight; wait for it and throw it away.
              state    <= FLUSH;
              imem_req <= 1'b0;
            end
          end else if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc_plus4;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            // A handshake in the same cycle is void: the word is squashed.
            instr_valid <= 1'b0;
            pc          <= redirect_target;
            imem_req    <= 1'b1;
            state       <= REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end

        FLUSH: begin
          if (redirect_valid) begin
            pc <= redirect_target;
          end
          // The stale response retires the outstanding access even when a
          // redirect lands in the same cycle, otherwise FLUSH could never exit.
          if (imem_rvalid) begin
            imem_req <= 1'b1;
            state    <= REQ;
          end
        end

        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: one DUT at RESET_PC=0 and a second at
// RESET_PC=32'hFFFF_FFFC driven in lockstep to observe pc wrap-around.

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;

  logic                         imem_req;
  logic [31:0]                  imem_addr;
  logic                         instr_valid;
  logic [31:0]                  instr;
  instruction_set_pkg::opcode_t opcode;
  instruction_set_pkg::func_t   func;
  logic [31:0]                  instr_pc;

  logic                         w_imem_req;
  logic [31:0]                  w_imem_addr;
  logic                         w_instr_valid;
  logic [31:0]                  w_instr;
  instruction_set_pkg::opcode_t w_opcode;
  instruction_set_pkg::func_t   w_func;
  logic [31:0]                  w_instr_pc;

  int n_pass;
  int n_total;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .func(func), .instr_pc(instr_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready),
    .instr(w_instr), .opcode(w_opcode), .func(w_func), .instr_pc(w_instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0000_0000;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    instr_ready    = 1'b1;

    // ---- reset values ----
    tick();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'h0000_0000);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'h0000_0000);
    chk("rst_ipc",   instr_pc,             32'h0000_0000);
    chk("rst_waddr", w_imem_addr,          32'hFFFF_FFFC);
    rst_n = 1'b1;

    // ---- zero-latency fetch stream at 0x0, 0x4, 0x8 ----
    tick(); // IDLE -> REQ
    chk("s1_req0",   {31'd0, imem_req},    32'd1);
    chk("s1_addr0",  imem_addr,            32'h0000_0000);
    chk("s1_waddr0", w_imem_addr,          32'hFFFF_FFFC);
    imem_rvalid = 1'b1; imem_rdata = 32'hA000_0001;
    tick(); // REQ -> HOLD
    chk("s1_valid0", {31'd0, instr_valid}, 32'd1);
    chk("s1_instr0", instr,                32'hA000_0001);
    chk("s1_ipc0",   instr_pc,             32'h0000_0000);
    chk("s1_reqlo0", {31'd0, imem_req},    32'd0);
    chk("s1_wipc0",  w_instr_pc,           32'hFFFF_FFFC);
    imem_rvalid = 1'b0;
    tick(); // HOLD -> REQ
    chk("s1_valid_lo", {31'd0, instr_valid}, 32'd0);
    chk("s1_addr1",  imem_addr,            32'h0000_0004);
    chk("s1_waddr1", w_imem_addr,          32'h0000_0000);
    imem_rvalid = 1'b1; imem_rdata = 32'hA000_0002;
    tick();
    chk("s1_ipc1",   instr_pc,             32'h0000_0004);
    chk("s1_instr1", instr,                32'hA000_0002);
    chk("s1_wipc1",  w_instr_pc,           32'h0000_0000);
    imem_rvalid = 1'b0;
    tick();
    chk("s1_addr2",  imem_addr,            32'h0000_0008);
    imem_rvalid = 1'b1; imem_rdata = 32'hA000_0003;
    tick();
    chk("s1_ipc2",   instr_pc,             32'h0000_0008);
    chk("s1_valid2", {31'd0, instr_valid}, 32'd1);
    imem_rvalid = 1'b0;

    // ---- hold under back-pressure ----
    rst_n = 1'b0;
    #2;
    chk("r2_valid", {31'd0, instr_valid}, 32'd0);
    chk("r2_instr", instr,                32'h0000_0000);
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b0;
    tick(); // REQ at 0x0
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
    tick(); // HOLD
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",  {31'd0, instr_valid}, 32'd1);
      chk("bp_instr",  instr,                32'h0000_0020);
      chk("bp_opcode", {26'd0, opcode},      32'd0);
      chk("bp_func",   {26'd0, func},        32'h0000_0020);
      chk("bp_req",    {31'd0, imem_req},    32'd0);
    end
    instr_ready = 1'b1;
    tick(); // HOLD -> REQ at 0x4
    chk("bp_addr",  imem_addr,            32'h0000_0004);
    chk("bp_req1",  {31'd0, imem_req},    32'd1);

    // ---- redirect during a 3-cycle-latency access ----
    tick(); // second cycle of the outstanding access
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick(); // REQ -> FLUSH
    chk("fl_req",   {31'd0, imem_req},    32'd0);
    chk("fl_valid", {31'd0, instr_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("fl_req2",  {31'd0, imem_req},    32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); // FLUSH -> REQ, stale word discarded
    chk("fl_valid2", {31'd0, instr_valid}, 32'd0);
    chk("fl_instr",  instr,                32'h0000_0020);
    chk("fl_addr",   imem_addr,            32'h0000_0100);
    chk("fl_req3",   {31'd0, imem_req},    32'd1);
    imem_rvalid = 1'b0;

    // ---- redirect in HOLD coinciding with a handshake ----
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick(); // HOLD, word from 0x100
    chk("hr_ipc",  instr_pc,             32'h0000_0100);
    imem_rvalid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    chk("hr_valid", {31'd0, instr_valid}, 32'd0);
    chk("hr_addr",  imem_addr,            32'h0000_0040);
    chk("hr_req",   {31'd0, imem_req},    32'd1);
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    chk("hr_ipc2",   instr_pc, 32'h0000_0040);
    chk("hr_instr2", instr,    32'hCAFE_F00D);
    imem_rvalid = 1'b0;
    tick(); // REQ at 0x44

    // ---- redirect and response in the same REQ cycle ----
    chk("rr_addr0", imem_addr, 32'h0000_0044);
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    chk("rr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rr_instr", instr,                32'hCAFE_F00D);
    chk("rr_addr",  imem_addr,            32'h0000_0200);
    chk("rr_req",   {31'd0, imem_req},    32'd1);
    imem_rvalid = 1'b0; redirect_valid = 1'b0;

    // ---- reset mid-request, late response afterwards ----
    rst_n = 1'b0;
    #2;
    chk("mr_req",   {31'd0, imem_req},    32'd0);
    chk("mr_addr",  imem_addr,            32'h0000_0000);
    chk("mr_valid", {31'd0, instr_valid}, 32'd0);
    chk("mr_instr", instr,                32'h0000_0000);
    chk("mr_ipc",   instr_pc,             32'h0000_0000);
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    tick(); // IDLE ignores the late response
    chk("mr_valid2", {31'd0, instr_valid}, 32'd0);
    chk("mr_instr2", instr,                32'h0000_0000);
    chk("mr_addr2",  imem_addr,            32'h0000_0000);
    chk("mr_req2",   {31'd0, imem_req},    32'd1);
    imem_rdata = 32'h0C00_0000;
    tick();
    chk("mr_instr3",  instr,           32'h0C00_0000);
    chk("mr_opcode3", {26'd0, opcode}, 32'd3);
    chk("mr_ipc3",    instr_pc,        32'h0000_0000);
    imem_rvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
